// File: rtl/padded_frame_pkg.sv
// Shared constants for the padded frame buffer: FSM encodings, default geometry and a width helper.
package padded_frame_pkg;

    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    localparam int DEF_WIDTH   = 400;
    localparam int DEF_HEIGHT  = 300;
    localparam int DEF_PIX_W   = 4;
    localparam int DEF_NCH     = 3;
    localparam int DEF_PAD     = 1;
    localparam int DEF_PAD_VAL = 0;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/padded_frame_buf_chan_ram.sv
// One channel of interior frame storage: synchronous write, combinational read, no reset.
// No flow control of its own; the owner decides when to write.
module chan_ram
    import padded_frame_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int DEPTH = DEF_WIDTH * DEF_HEIGHT,
    localparam int A_W  = cw(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [A_W-1:0]   waddr_i,
    input  logic [PIX_W-1:0] wdata_i,
    input  logic [A_W-1:0]   raddr_i,
    output logic [PIX_W-1:0] rdata_o
);

    logic [PIX_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/padded_frame_buf.sv
// Buffers one channel-serial frame, then replays it with a PAD-wide constant border, one pixel per cycle.
// First pixel one cycle after the frame completes; input stalls while draining, output holds under out_ready=0.
module padded_frame_buf
    import padded_frame_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    parameter int PIX_W   = DEF_PIX_W,
    parameter int NCH     = DEF_NCH,
    parameter int PAD     = DEF_PAD,
    parameter int PAD_VAL = DEF_PAD_VAL
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PIX_W-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*PIX_W-1:0] out_data,
    output logic                 out_eol,
    output logic                 out_last
);

    localparam int PW    = WIDTH + 2 * PAD;
    localparam int PH    = HEIGHT + 2 * PAD;
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int CH_W  = cw(NCH);
    localparam int X_W   = cw(WIDTH);
    localparam int Y_W   = cw(HEIGHT);
    localparam int RX_W  = cw(PW);
    localparam int RY_W  = cw(PH);
    localparam int A_W   = cw(DEPTH);

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);
    localparam logic [X_W-1:0]  X_LAST  = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(HEIGHT - 1);
    localparam logic [RX_W-1:0] RX_LAST = RX_W'(PW - 1);
    localparam logic [RY_W-1:0] RY_LAST = RY_W'(PH - 1);

    logic [0:0]           state_q,     state_d;
    logic [CH_W-1:0]      wr_ch_q,     wr_ch_d;
    logic [X_W-1:0]       wr_x_q,      wr_x_d;
    logic [Y_W-1:0]       wr_y_q,      wr_y_d;
    logic [RX_W-1:0]      rd_x_q,      rd_x_d;
    logic [RY_W-1:0]      rd_y_q,      rd_y_d;
    logic                 out_valid_q, out_valid_d;
    logic [NCH*PIX_W-1:0] out_data_q,  out_data_d;
    logic                 out_eol_q,   out_eol_d;
    logic                 out_last_q,  out_last_d;

    logic                 wr_en;
    logic                 load;
    logic                 interior;
    logic                 rd_last;
    logic [NCH-1:0]       ch_we;
    logic [A_W-1:0]       waddr;
    logic [A_W-1:0]       raddr;
    logic [NCH*PIX_W-1:0] rd_pix;
    logic [NCH*PIX_W-1:0] pad_pix;

    assign in_ready = (state_q == S_FILL);
    assign wr_en    = in_valid && (state_q == S_FILL);
    assign load     = (state_q == S_DRAIN) && (!out_valid_q || out_ready);
    assign rd_last  = (rd_x_q == RX_LAST) && (rd_y_q == RY_LAST);

    // Border is decided purely by position; only interior pixels have storage.
    assign interior = (int'(rd_x_q) >= PAD) && (int'(rd_x_q) < WIDTH + PAD) &&
                      (int'(rd_y_q) >= PAD) && (int'(rd_y_q) < HEIGHT + PAD);

    assign waddr = A_W'(int'(wr_y_q) * WIDTH + int'(wr_x_q));
    assign raddr = interior ? A_W'((int'(rd_y_q) - PAD) * WIDTH + int'(rd_x_q) - PAD) : '0;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign ch_we[c]                     = wr_en && (wr_ch_q == CH_W'(c));
        assign pad_pix[c*PIX_W +: PIX_W]    = PIX_W'(PAD_VAL);

        chan_ram #(
            .PIX_W (PIX_W),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk     (clk),
            .we_i    (ch_we[c]),
            .waddr_i (waddr),
            .wdata_i (in_data),
            .raddr_i (raddr),
            .rdata_o (rd_pix[c*PIX_W +: PIX_W])
        );
    end

    always_comb begin
        state_d     = state_q;
        wr_ch_d     = wr_ch_q;
        wr_x_d      = wr_x_q;
        wr_y_d      = wr_y_q;
        rd_x_d      = rd_x_q;
        rd_y_d      = rd_y_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_eol_d   = out_eol_q;
        out_last_d  = out_last_q;

        if (wr_en) begin
            if (wr_ch_q == CH_LAST) begin
                wr_ch_d = '0;
                if (wr_x_q == X_LAST) begin
                    wr_x_d = '0;
                    if (wr_y_q == Y_LAST) begin
                        wr_y_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        wr_y_d = wr_y_q + Y_W'(1);
                    end
                end else begin
                    wr_x_d = wr_x_q + X_W'(1);
                end
            end else begin
                wr_ch_d = wr_ch_q + CH_W'(1);
            end
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = interior ? rd_pix : pad_pix;
            out_eol_d   = (rd_x_q == RX_LAST);
            out_last_d  = rd_last;
            if (rd_x_q == RX_LAST) begin
                rd_x_d = '0;
                if (rd_y_q == RY_LAST) begin
                    rd_y_d  = '0;
                    state_d = S_FILL;
                end else begin
                    rd_y_d = rd_y_q + RY_W'(1);
                end
            end else begin
                rd_x_d = rd_x_q + RX_W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FILL;
            wr_ch_q     <= '0;
            wr_x_q      <= '0;
            wr_y_q      <= '0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_eol_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ch_q     <= wr_ch_d;
            wr_x_q      <= wr_x_d;
            wr_y_q      <= wr_y_d;
            rd_x_q      <= rd_x_d;
            rd_y_q      <= rd_y_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_eol_q   <= out_eol_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_eol   = out_eol_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_padded_frame_buf.sv
// Bench for padded_frame_buf: three 4x3x3 instances (PAD=1/PAD_VAL=0, PAD=1/PAD_VAL=F, PAD=0) share one input stream.
module tb_padded_frame_buf;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int NC = 3;
    localparam int NB = W * H * NC;
    localparam int NI = 3;
    localparam int PADS [NI] = '{1, 1, 0};
    localparam int PVS  [NI] = '{0, 15, 0};

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic [3:0]          in_data = 4'h0;
    logic [NI-1:0]       ordy = '1;
    logic [NI-1:0]       ird, ov, oeol, olast;
    logic [NI-1:0][11:0] od;

    int pad_of [NI] = '{1, 1, 0};
    int pv_of  [NI] = '{0, 15, 0};

    // Model state per instance: captured frame, pending expected outputs, accepted outputs.
    logic [3:0]  mm  [NI][NB];
    logic [13:0] ex  [NI][64];
    logic [13:0] cap [NI][40];
    int beat [NI];
    int hd   [NI];
    int nq   [NI];
    int ncap [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        padded_frame_buf #(
            .WIDTH   (W),
            .HEIGHT  (H),
            .PIX_W   (4),
            .NCH     (NC),
            .PAD     (PADS[g]),
            .PAD_VAL (PVS[g])
        ) u_dut (
            .clk       (clk),
            .reset     (rst),
            .in_valid  (in_valid),
            .in_ready  (ird[g]),
            .in_data   (in_data),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_data  (od[g]),
            .out_eol   (oeol[g]),
            .out_last  (olast[g])
        );
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h", name, inst, act, exp);
        end
    endtask

    // Padded pixel i of instance g, derived from the stored input frame.
    function automatic logic [13:0] model_pix(input int g, input int i);
        int pad, pw, ph, x, y, base;
        logic [3:0]  pv;
        logic [11:0] d;
        pad = pad_of[g];
        pw  = W + 2 * pad;
        ph  = H + 2 * pad;
        x   = i % pw;
        y   = i / pw;
        pv  = 4'(pv_of[g]);
        if (x < pad || x >= W + pad || y < pad || y >= H + pad) begin
            d = {3{pv}};
        end else begin
            base = ((y - pad) * W + (x - pad)) * NC;
            for (int c = 0; c < NC; c++) d[c*4 +: 4] = mm[g][base + c];
        end
        return {(i == pw * ph - 1), (x == pw - 1), d};
    endfunction

    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (rst) begin
                beat[g] = 0;
                hd[g]   = 0;
                nq[g]   = 0;
                chk("reset_valid", g, ov[g], 0);
                chk("reset_in_ready", g, ird[g], 1);
            end else begin
                if (ov[g]) begin
                    if (nq[g] == 0) begin
                        chk("spurious_valid", g, ov[g], 0);
                    end else begin
                        chk("out_data", g, od[g], ex[g][hd[g]][11:0]);
                        chk("out_eol", g, oeol[g], ex[g][hd[g]][12]);
                        chk("out_last", g, olast[g], ex[g][hd[g]][13]);
                        if (nq[g] > 1) chk("in_ready_drain", g, ird[g], 0);
                        if (ordy[g]) begin
                            if (ncap[g] < 40) begin
                                cap[g][ncap[g]] = {olast[g], oeol[g], od[g]};
                                ncap[g]++;
                            end
                            hd[g] = (hd[g] + 1) % 64;
                            nq[g]--;
                        end
                    end
                end else if (nq[g] == 0) begin
                    chk("idle_in_ready", g, ird[g], 1);
                end
                if (in_valid && ird[g]) begin
                    mm[g][beat[g]] = in_data;
                    beat[g]++;
                    if (beat[g] == NB) begin
                        beat[g] = 0;
                        for (int i = 0; i < (W + 2 * pad_of[g]) * (H + 2 * pad_of[g]); i++) begin
                            ex[g][(hd[g] + nq[g]) % 64] = model_pix(g, i);
                            nq[g]++;
                        end
                    end
                end
            end
        end
    end

    task automatic send_beats(input int lo, input int hi, input bit gaps);
        for (int b = lo; b < hi; b++) begin
            if (gaps && (b % 7 == 3)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = 4'((b / NC) % 16);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input bit rnd);
        int busy;
        busy = 1;
        for (int cyc = 0; cyc < 2000 && busy != 0; cyc++) begin
            @(posedge clk); #1;
            if (rnd) ordy = 3'($urandom);
            busy = nq[0] + nq[1] + nq[2];
        end
        chk("drain_timeout", 0, busy, 0);
        ordy = '1;
    endtask

    task automatic clear_cap();
        for (int g = 0; g < NI; g++) ncap[g] = 0;
    endtask

    // Hand-derived expectations for the index-mod-16 stream.
    task automatic check_lits();
        int nb;
        chk("count", 0, ncap[0], 30);
        chk("count", 1, ncap[1], 30);
        chk("count", 2, ncap[2], 12);
        chk("out0", 0, cap[0][0][11:0], 12'h000);
        chk("out7", 0, cap[0][7][11:0], 12'h000);
        chk("out8", 0, cap[0][8][11:0], 12'h111);
        chk("out0", 1, cap[1][0][11:0], 12'hFFF);
        chk("out7", 1, cap[1][7][11:0], 12'h000);
        chk("out8", 1, cap[1][8][11:0], 12'h111);
        nb = 0;
        for (int k = 0; k < 30; k++) begin
            chk("eol", 0, cap[0][k][12], (k % 6 == 5));
            chk("last", 0, cap[0][k][13], (k == 29));
            if (cap[1][k][11:0] == 12'hFFF) nb++;
        end
        chk("border_count", 1, nb, 18);
        for (int k = 0; k < 12; k++) begin
            chk("pad0_data", 2, cap[2][k][11:0], 12'(k * 12'h111));
            chk("pad0_eol", 2, cap[2][k][12], (k % 4 == 3));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 0, ov, 0);
        chk("rst_out_data", 0, od, 0);
        chk("rst_eol_last", 0, {oeol, olast}, 0);
        chk("rst_in_ready", 0, ird, 3'b111);
        @(posedge clk); #1;

        // Frame with idle input gaps and out_ready held high: timing and rate.
        clear_cap();
        send_beats(0, NB, 1'b1);
        @(negedge clk);
        chk("first_valid_early", 0, ov, 0);
        @(negedge clk);
        chk("first_valid", 0, ov, 3'b111);
        repeat (11) @(negedge clk);
        chk("rate_pad0_last", 2, {ov[2], olast[2]}, 2'b11);
        @(negedge clk);
        chk("pad0_valid_drop", 2, ov[2], 0);
        repeat (17) @(negedge clk);
        chk("rate_pad1_last", 0, {ov[1:0], olast[1:0]}, 4'b1111);
        @(negedge clk);
        chk("valid_drop", 0, ov, 0);
        @(posedge clk); #1;
        wait_drain(1'b0);
        check_lits();

        // Random backpressure.
        clear_cap();
        send_beats(0, NB, 1'b0);
        wait_drain(1'b1);
        check_lits();

        // Reset in the middle of a frame, then a clean frame.
        send_beats(0, 20, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_in_ready", 0, ird, 3'b111);
        chk("midrst_valid", 0, ov, 0);
        clear_cap();
        send_beats(0, NB, 1'b0);
        wait_drain(1'b0);
        check_lits();

        // Hold each final pixel and overlap the next frame's first beats.
        clear_cap();
        send_beats(0, NB, 1'b0);
        for (int cyc = 0; cyc < 300 && ordy != 0; cyc++) begin
            @(posedge clk); #1;
            for (int g = 0; g < NI; g++) if (ov[g] && olast[g]) ordy[g] = 1'b0;
        end
        chk("hold_timeout", 0, ordy, 0);
        chk("overlap_in_ready", 0, ird, 3'b111);
        send_beats(0, 6, 1'b0);
        chk("overlap_accepted", 0, {beat[2], beat[1], beat[0]}, {32'd6, 32'd6, 32'd6});
        chk("held_data", 0, od[0], 12'h000);
        chk("held_data", 1, od[1], 12'hFFF);
        chk("held_data", 2, od[2], 12'hBBB);
        chk("held_last", 0, {ov, olast}, 6'b111111);
        ordy = '1;
        send_beats(6, NB, 1'b0);
        wait_drain(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
